// File: rtl/m_dram_arbiter.sv
// Two-port round-robin arbiter in front of a single DRAM controller.
// One transaction at a time: grant, issue a one-cycle command, wait for busy to fall, ack.
module m_dram_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [2:0]  r0_ctrl,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [2:0]  r1_ctrl,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,

    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    output logic [2:0]  w_dram_ctrl,
    output logic        w_dram_we_t,
    output logic        w_dram_le,
    input  logic [31:0] w_dram_odata,
    input  logic        w_dram_busy,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAcc,
        StWaitDone,
        StAck
    } state_e;

    state_e            state_q;
    logic              last_q;   // 1: port 1 was served last, so port 0 wins a tie
    logic              owner_q;
    logic              we_q;
    logic [CntW-1:0]   cnt_q;

    logic              pick1;
    logic              in_wait;
    logic              done_ok;
    logic              abort;
    logic              finish;
    logic [31:0]       cap_data;

    always_comb begin
        pick1    = r1_req && (!r0_req || !last_q);
        in_wait  = (state_q == StWaitAcc) || (state_q == StWaitDone);
        done_ok  = (state_q == StWaitDone) && !w_dram_busy;
        // A completion in the final counted cycle wins over the abort.
        abort    = in_wait && !done_ok && (cnt_q == CntLast);
        finish   = done_ok || abort;
        cap_data = abort ? 32'h0 : w_dram_odata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rdata     <= 32'h0;
            r1_rdata     <= 32'h0;
            w_dram_addr  <= 32'h0;
            w_dram_wdata <= 32'h0;
            w_dram_ctrl  <= 3'h0;
            w_dram_we_t  <= 1'b0;
            w_dram_le    <= 1'b0;
            o_grant      <= 2'b00;
            o_timeout    <= 1'b0;
        end else begin
            w_dram_we_t <= 1'b0;
            w_dram_le   <= 1'b0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if ((r0_req || r1_req) && !w_dram_busy) begin
                        owner_q      <= pick1;
                        last_q       <= pick1;
                        o_grant      <= pick1 ? 2'b10 : 2'b01;
                        we_q         <= pick1 ? r1_we : r0_we;
                        w_dram_addr  <= pick1 ? r1_addr : r0_addr;
                        w_dram_wdata <= pick1 ? r1_wdata : r0_wdata;
                        w_dram_ctrl  <= pick1 ? r1_ctrl : r0_ctrl;
                        // Command strobes are registered so they are high exactly in StIssue.
                        w_dram_we_t  <= pick1 ? r1_we : r0_we;
                        w_dram_le    <= pick1 ? !r1_we : !r0_we;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWaitAcc;
                end
                StWaitAcc, StWaitDone: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (finish) begin
                        state_q <= StAck;
                        if (owner_q) begin
                            r1_ack <= 1'b1;
                            if (!we_q) r1_rdata <= cap_data;
                        end else begin
                            r0_ack <= 1'b1;
                            if (!we_q) r0_rdata <= cap_data;
                        end
                        if (abort) o_timeout <= 1'b1;
                    end else if ((state_q == StWaitAcc) && w_dram_busy) begin
                        state_q <= StWaitDone;
                    end
                end
                StAck: begin
                    o_grant <= 2'b00;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Randomized bench for m_dram_arbiter: a transaction-timeline reference model predicts
// grant, command, ack, read data and timeout for every cycle.
module tb_m_dram_arbiter;

    localparam int unsigned TO = 8;
    localparam int NCYC = 4000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [2:0]  r0_ctrl, r1_ctrl;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] w_dram_addr, w_dram_wdata, w_dram_odata;
    logic [2:0]  w_dram_ctrl;
    logic        w_dram_we_t, w_dram_le, w_dram_busy;
    logic [1:0]  o_grant;
    logic        o_timeout;

    m_dram_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ctrl(r0_ctrl), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ctrl(r1_ctrl), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
        .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le), .w_dram_odata(w_dram_odata),
        .w_dram_busy(w_dram_busy), .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester side: 0 idle, 1 requesting, 2 granted and waiting for ack.
    int          pst [2];
    logic        preq [2];
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [2:0]  pctrl [2];

    // Current/last transaction timeline: grant visible at t_i, busy fall at t_f, ack at t_a.
    bit          tv;
    int          t_own, t_i, t_a, t_f, t_dly, t_dur;
    bit          t_we, t_nev;
    logic [31:0] t_addr, t_wdata, fall_data;
    logic [2:0]  t_ctrl;
    int          last_srv, acks, win;
    bit          do_rst;

    logic [31:0] rd_e [2];
    bit          to_e;
    logic [31:0] addr_e, wdata_e;
    logic [2:0]  ctrl_e;
    logic [1:0]  exp_grant, exp_cmd, exp_ack;

    task automatic model_reset();
        tv = 1'b0;
        last_srv = 1;
        rd_e[0] = '0;
        rd_e[1] = '0;
        to_e = 1'b0;
        addr_e = '0;
        wdata_e = '0;
        ctrl_e = '0;
        for (int p = 0; p < 2; p++) begin
            pst[p] = 0;
            preq[p] = 1'b0;
            pwe[p] = 1'b0;
            paddr[p] = '0;
            pwdata[p] = '0;
            pctrl[p] = '0;
        end
    endtask

    task automatic drive_pins();
        r0_req = preq[0]; r0_we = pwe[0]; r0_addr = paddr[0];
        r0_wdata = pwdata[0]; r0_ctrl = pctrl[0];
        r1_req = preq[1]; r1_we = pwe[1]; r1_addr = paddr[1];
        r1_wdata = pwdata[1]; r1_ctrl = pctrl[1];
    endtask

    initial begin
        RST = 1'b1;
        w_dram_busy = 1'b0;
        w_dram_odata = '0;
        acks = 0;
        fall_data = '0;
        model_reset();
        drive_pins();
        repeat (2) @(posedge CLK);

        while (cyc < NCYC) begin
            @(negedge CLK);
            // Expected outputs for this cycle, from the transaction timeline.
            if (tv && cyc == t_i) begin
                addr_e = t_addr;
                wdata_e = t_wdata;
                ctrl_e = t_ctrl;
            end
            exp_grant = (tv && cyc >= t_i && cyc <= t_a) ? (t_own == 1 ? 2'b10 : 2'b01) : 2'b00;
            exp_cmd = (tv && cyc == t_i) ? {t_we, !t_we} : 2'b00;
            exp_ack = (tv && cyc == t_a) ? exp_grant : 2'b00;
            if (tv && cyc == t_a) begin
                if (!t_we) rd_e[t_own] = t_nev ? 32'h0 : fall_data;
                if (t_nev) to_e = 1'b1;
                acks++;
            end
            check_eq("grant", o_grant, exp_grant);
            check_eq("cmd_we_le", {w_dram_we_t, w_dram_le}, exp_cmd);
            check_eq("ack", {r1_ack, r0_ack}, exp_ack);
            check_eq("rdata0", r0_rdata, rd_e[0]);
            check_eq("rdata1", r1_rdata, rd_e[1]);
            check_eq("timeout", o_timeout, to_e);
            check_eq("addr_wdata", {w_dram_addr, w_dram_wdata}, {addr_e, wdata_e});
            check_eq("ctrl", w_dram_ctrl, ctrl_e);

            w_dram_odata = $urandom;
            do_rst = ($urandom_range(0, 199) == 0);
            if (do_rst) begin
                RST = 1'b1;
                w_dram_busy = 1'b0;
                model_reset();
                drive_pins();
                cyc++;
                continue;
            end
            RST = 1'b0;

            if (tv && cyc == t_a) begin
                pst[t_own] = 0;
                preq[t_own] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                case (pst[p])
                    0: if ($urandom_range(0, 99) < 30) begin
                        pst[p] = 1;
                        preq[p] = 1'b1;
                        pwe[p] = $urandom_range(0, 1) == 1;
                        paddr[p] = $urandom;
                        pwdata[p] = $urandom;
                        pctrl[p] = 3'($urandom_range(0, 7));
                    end
                    1: if ($urandom_range(0, 99) < 4) begin
                        pst[p] = 0;
                        preq[p] = 1'b0;
                    end
                    default: if ($urandom_range(0, 99) < 25) preq[p] = 1'b0;
                endcase
            end

            // DRAM responder; spurious busy only while no transaction is outstanding.
            if (tv && cyc <= t_a) begin
                w_dram_busy = !t_nev && cyc >= t_i + 1 + t_dly && cyc <= t_i + t_dly + t_dur;
                if (!t_nev && cyc == t_f) fall_data = w_dram_odata;
            end else begin
                w_dram_busy = ($urandom_range(0, 3) == 0);
            end

            if ((!tv || cyc > t_a) && !w_dram_busy && (preq[0] || preq[1])) begin
                if (preq[0] && preq[1]) win = (last_srv == 0) ? 1 : 0;
                else win = preq[1] ? 1 : 0;
                last_srv = win;
                tv = 1'b1;
                t_own = win;
                t_we = pwe[win];
                t_addr = paddr[win];
                t_wdata = pwdata[win];
                t_ctrl = pctrl[win];
                t_i = cyc + 1;
                t_nev = ($urandom_range(0, 9) == 0);
                t_dly = $urandom_range(0, 2);
                t_dur = $urandom_range(1, 4);
                t_f = t_i + 1 + t_dly + t_dur;
                t_a = t_nev ? t_i + 1 + TO : t_f + 1;
                pst[win] = 2;
            end
            drive_pins();
            cyc++;
        end

        check_eq("acks_seen", acks != 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
